// File: rtl/mem_burst_reader.sv
// mem_burst_reader
//   Reads a burst of consecutive words from a small synchronous-read memory
//   and streams them out over a valid/ready interface. It keeps at most two
//   words outstanding (in flight from memory plus held in a 2-entry skid
//   buffer), so a word returning from memory is never lost while the stream
//   is stalled.
//
// Optional feature (macro MEM_BURST_READER_CSUM_EN):
//   adds output csum, the modulo-2^DAT_W sum of all words transferred in the
//   current burst. It is cleared on an accepted start and on rst, and it is
//   valid while done=1. Without the macro there is no csum port and no
//   checksum logic.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle burst request, honoured only in IDLE
//   base_adr   in   first memory address of the burst
//   len        in   burst length in words, 0..16
//   busy       out  high in READ, DRAIN and FINISH
//   done       out  one-cycle pulse in FINISH
//   adr        out  memory read address
//   dat_r      in   memory read data, valid one cycle after adr
//   out_data   out  stream data
//   out_valid  out  stream data valid
//   out_ready  in   downstream accept
//   csum       out  burst checksum (only with MEM_BURST_READER_CSUM_EN)
//   dbg_state  out  current FSM state, for debug and checkers
//
// Stream handshake: a word transfers in a cycle where out_valid and out_ready
// are both high. Once out_valid is raised, out_valid and out_data stay
// unchanged until that transfer happens. out_ready may change at any time
// and does not depend on out_valid.
module mem_burst_reader #(
  parameter int ADR_W = 4,
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADR_W-1:0] adr,
  input  logic [DAT_W-1:0] dat_r,
  output logic [DAT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MEM_BURST_READER_CSUM_EN
  output logic [DAT_W-1:0] csum,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADR_W-1:0] ADR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};
  localparam logic [ADR_W:0]   LEN_ONE = {{ADR_W{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [ADR_W-1:0]   adr_q;
  logic [ADR_W:0]     len_q;
  logic [ADR_W:0]     issue_cnt_q;
  logic [ADR_W:0]     xfer_cnt_q;
  // High in the cycle where the word addressed in the previous cycle is on dat_r.
  logic               rvalid_q;
  logic [DAT_W-1:0]   buf_q [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         cnt_q, cnt_d;

  logic               accept;
  logic               issue;
  logic               xfer;
  logic               push;
  logic               pop;
  logic [1:0]         occupancy;

  assign accept    = (state_q == IDLE) && start;
  assign occupancy = {1'b0, rvalid_q} + cnt_q;

  // Buffered words always go first; a returning word is passed straight
  // through only when the buffer is empty, which keeps address order.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    if (cnt_q != 2'd0) begin
      out_valid = 1'b1;
      out_data  = buf_q[rd_ptr_q];
    end else if (rvalid_q) begin
      out_valid = 1'b1;
      out_data  = dat_r;
    end
  end

  assign xfer = out_valid && out_ready;
  // A returning word is buffered unless it leaves this same cycle.
  assign push = rvalid_q && !((cnt_q == 2'd0) && out_ready);
  assign pop  = (cnt_q != 2'd0) && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Next-state logic. The issue limit of two outstanding words is what
  // makes a 2-entry buffer sufficient.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FINISH : READ;
        end
      end
      READ: begin
        issue = (occupancy < 2'd2);
        if (issue && (issue_cnt_q == (len_q - LEN_ONE))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && (xfer_cnt_q == (len_q - LEN_ONE))) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      rvalid_q    <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= issue;
      if (accept) begin
        adr_q       <= base_adr;
        len_q       <= len;
        issue_cnt_q <= '0;
        xfer_cnt_q  <= '0;
      end else begin
        if (issue) begin
          // Natural wrap of the ADR_W-bit address gives modulo addressing.
          adr_q       <= adr_q + ADR_ONE;
          issue_cnt_q <= issue_cnt_q + LEN_ONE;
        end
        if (xfer) begin
          xfer_cnt_q <= xfer_cnt_q + LEN_ONE;
        end
      end
      if (push) begin
        buf_q[wr_ptr_q] <= dat_r;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign adr       = adr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign dbg_state = state_q;

`ifdef MEM_BURST_READER_CSUM_EN
  logic [DAT_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (xfer) begin
      csum_q <= csum_q + out_data;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Testbench for mem_burst_reader: a behavioural 16x8 memory, a driver that
// issues bursts and pushes the expected words (memory contents at
// (base+i) mod 16) into a queue, and a monitor that pops and compares on
// every stream transfer.
module tb_mem_burst_reader;
  localparam int ADR_W = 4;
  localparam int DAT_W = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADR_W-1:0] base_adr;
  logic [ADR_W:0]   len;
  logic             busy;
  logic             done;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_r;
  logic [DAT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       dbg_state;
`ifdef MEM_BURST_READER_CSUM_EN
  logic [DAT_W-1:0] csum;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: data appears one cycle after the address.
  logic [DAT_W-1:0] mem [DEPTH];
  always @(posedge clk) dat_r <= mem[adr];

  mem_burst_reader #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .adr       (adr),
    .dat_r     (dat_r),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MEM_BURST_READER_CSUM_EN
    .csum      (csum),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DAT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int first_valid_cyc;
  int last_xfer_cyc;
  int done_cyc;
  int busy_cyc;
  int valid_seen;
  int burst_xfers;
  int done_count = 0;
  int start_cyc;
  int rmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic clear_stats();
    first_valid_cyc = -1;
    last_xfer_cyc   = -1;
    done_cyc        = -1;
    busy_cyc        = 0;
    valid_seen      = 0;
    burst_xfers     = 0;
  endtask

  // ---------------- out_ready driver ----------------
  // mode 0: held high, 1: toggles every cycle, 2: random (mostly high)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic             prev_stall;
    logic [DAT_W-1:0] prev_data;
    logic             prev_done;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (out_valid) begin
          valid_seen++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_stall) begin
          check("stall_valid_held", 32'(out_valid), 32'(1));
          check("stall_data_held", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL extra_word: got 0x%0h with no word expected", out_data);
          end else begin
            logic [DAT_W-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
              n_errors++;
              $display("FAIL stream_data: got 0x%0h expected 0x%0h", out_data, e);
            end
          end
          burst_xfers++;
          last_xfer_cyc = cyc;
        end
        if (done) begin
          check("done_single_cycle", 32'(prev_done), 32'(0));
          done_count++;
          done_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_done  = done;
      end
    end
  end

  // ---------------- driver ----------------
  int last_csum;

  task automatic run_burst(input int base, input int ln, input int mode, input bit tchk);
    int exp_sum;
    int guard;
    int d0;
    exp_sum = 0;
    rmode = mode;
    for (int i = 0; i < ln; i++) begin
      logic [ADR_W-1:0] a;
      logic [DAT_W-1:0] w;
      a = 4'((base + i) % DEPTH);
      w = mem[a];
      exp_q.push_back(w);
      exp_sum = exp_sum + int'(w);
    end
    clear_stats();
    d0 = done_count;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_adr  = base[ADR_W-1:0];
    len       = ln[ADR_W:0];
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 300) begin
      // Stray start pulses while busy must be ignored.
      if (busy && $urandom_range(0, 3) == 0) begin
        start    = 1'b1;
        base_adr = 4'($urandom);
        len      = 5'($urandom_range(0, 16));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    start = 1'b0;
    check("done_within_budget", 32'(guard < 300), 32'(1));
`ifdef MEM_BURST_READER_CSUM_EN
    check("csum_at_done", 32'(csum), 32'(exp_sum % 256));
    last_csum = int'(csum);
`else
    last_csum = exp_sum % 256;
`endif
    @(negedge clk);
    #1;
    check("all_words_delivered", 32'(exp_q.size()), 32'(0));
    check("word_count", 32'(burst_xfers), 32'(ln));
    check("one_done_per_burst", 32'(done_count), 32'(d0 + 1));
    if (ln == 0) begin
      check("len0_no_valid", 32'(valid_seen), 32'(0));
      check("len0_busy_cycles", 32'(busy_cyc), 32'(1));
    end else if (tchk) begin
      check("first_valid_latency", 32'(first_valid_cyc), 32'(start_cyc + 2));
      check("back_to_back_words", 32'(last_xfer_cyc), 32'(first_valid_cyc + ln - 1));
      check("done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
      check("busy_cycles", 32'(busy_cyc), 32'(ln + 2));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    base_adr  = '0;
    len       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_adr", 32'(adr), 32'(0));
    check("reset_out_data", 32'(out_data), 32'(0));
    rst = 1'b0;

    // Full memory sweep, then a wrapping burst back-to-back.
    run_burst(0, 16, 0, 1'b1);
    run_burst(14, 4, 0, 1'b1);
    // Stalling every other cycle.
    run_burst(3, 8, 1, 1'b0);
    // Empty burst.
    run_burst(5, 0, 0, 1'b1);

    // Reset in the middle of a burst.
    rmode = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[4'((2 + i) % DEPTH)]);
    clear_stats();
    @(posedge clk);
    #1;
    start    = 1'b1;
    base_adr = 4'd2;
    len      = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (burst_xfers < 3 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst_wait_budget", 32'(guard < 100), 32'(1));
    d0  = done_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_count), 32'(d0));
    run_burst(9, 8, 0, 1'b1);

`ifdef MEM_BURST_READER_CSUM_EN
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h80 + i);
    run_burst(0, 16, 0, 1'b1);
    check("csum_0x80_sweep", 32'(last_csum), 32'(8'h78));
`endif

    // Randomised bursts over random memory contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 25; n++) begin
      int m;
      m = $urandom_range(0, 2);
      run_burst($urandom_range(0, 15), $urandom_range(0, 16), m, (m == 0));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
